// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings and small helpers for the LED pattern controller.
package led_pattern_ctrl_pkg;

  // Display modes, in the order key_mode steps through them.
  typedef enum logic [1:0] {
    MODE_CHASE = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_PING  = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // Step-rate selects; 2'd3 is never produced.
  typedef enum logic [1:0] {
    SPD_1X = 2'd0,
    SPD_2X = 2'd1,
    SPD_4X = 2'd2
  } speed_e;

  // Ping-pong travel direction (the only pattern-side state besides led).
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Mode sequence: chase -> blink -> ping-pong -> count -> chase.
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_CHASE: r = MODE_BLINK;
      MODE_BLINK: r = MODE_PING;
      MODE_PING:  r = MODE_COUNT;
      default:    r = MODE_CHASE;
    endcase
    return r;
  endfunction

  // Speed sequence: 1x -> 2x -> 4x -> 1x.
  function automatic speed_e next_speed(input speed_e s);
    speed_e r;
    case (s)
      SPD_1X:  r = SPD_2X;
      SPD_2X:  r = SPD_4X;
      default: r = SPD_1X;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, hold counter, one pulse per press.
module key_debounce
  import led_pattern_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic press_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CNT - 2);

  logic          key_meta;
  logic          key_sync;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          pulse_n;

  // Synchroniser; resets to the released (high) level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  // Hold counter clears on release, saturates while held; fire once on the way up.
  always_comb begin
    cnt_n   = cnt_q;
    pulse_n = 1'b0;
    if (key_sync) begin
      cnt_n = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_n = cnt_q + CW'(1);
      end
      pulse_n = (cnt_q == CNT_FIRE);
    end
  end

  // Counter and registered press pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      press_pulse <= 1'b0;
    end else begin
      cnt_q       <= cnt_n;
      press_pulse <= pulse_n;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Key-driven LED pattern generator: chase, blink, ping-pong and binary count.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int unsigned LED_NUM      = 4,
  parameter int unsigned STEP_CNT     = 25000000,
  parameter int unsigned DEBOUNCE_CNT = 1000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               key_mode,
  input  logic               key_speed,
  output logic [LED_NUM-1:0] led,
  output logic [1:0]         mode_o,
  output logic [1:0]         speed_o
);

  localparam int unsigned TW = $clog2(STEP_CNT);
  localparam logic [TW-1:0] LAST_1X = TW'(STEP_CNT - 1);
  localparam logic [TW-1:0] LAST_2X = TW'((STEP_CNT >> 1) - 1);
  localparam logic [TW-1:0] LAST_4X = TW'((STEP_CNT >> 2) - 1);
  localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);

  logic               mode_pulse;
  logic               speed_pulse;
  logic               any_pulse;

  mode_e              mode_q;
  mode_e              mode_n;
  speed_e             speed_q;
  speed_e             speed_n;
  logic [TW-1:0]      step_q;
  logic [TW-1:0]      step_n;
  logic [TW-1:0]      step_last;
  logic               tick;
  logic [LED_NUM-1:0] led_q;
  logic [LED_NUM-1:0] led_n;
  dir_e               dir_q;
  dir_e               dir_n;

  key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_key_mode (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_mode),
    .press_pulse (mode_pulse)
  );

  key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_key_speed (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_speed),
    .press_pulse (speed_pulse)
  );

  assign any_pulse = mode_pulse | speed_pulse;

  // Mode and speed selects advance on their press pulses.
  always_comb begin
    mode_n  = mode_q;
    speed_n = speed_q;
    if (mode_pulse) begin
      mode_n = next_mode(mode_q);
    end
    if (speed_pulse) begin
      speed_n = next_speed(speed_q);
    end
  end

  // Step timer: period shrinks with speed; any key pulse restarts it without a tick.
  always_comb begin
    case (speed_q)
      SPD_2X:  step_last = LAST_2X;
      SPD_4X:  step_last = LAST_4X;
      default: step_last = LAST_1X;
    endcase
    tick   = (step_q == step_last) && !any_pulse;
    step_n = step_q + TW'(1);
    if (any_pulse || (step_q == step_last)) begin
      step_n = '0;
    end
  end

  // Pattern next state: a mode load overrides any tick in the same cycle.
  always_comb begin
    led_n = led_q;
    dir_n = dir_q;
    if (mode_pulse) begin
      dir_n = DIR_UP;
      case (mode_n)
        MODE_CHASE: led_n = LED_ONE;
        MODE_PING:  led_n = LED_ONE;
        default:    led_n = '0;
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_CHASE: begin
          led_n = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
        end
        MODE_BLINK: begin
          led_n = ~led_q;
        end
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            if (led_q[LED_NUM-1]) begin
              led_n = led_q >> 1;
              dir_n = DIR_DOWN;
            end else begin
              led_n = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_n = led_q << 1;
              dir_n = DIR_UP;
            end else begin
              led_n = led_q >> 1;
            end
          end
        end
        default: begin
          led_n = led_q + LED_ONE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q  <= MODE_CHASE;
      speed_q <= SPD_1X;
      step_q  <= '0;
      led_q   <= LED_ONE;
      dir_q   <= DIR_UP;
    end else begin
      mode_q  <= mode_n;
      speed_q <= speed_n;
      step_q  <= step_n;
      led_q   <= led_n;
      dir_q   <= dir_n;
    end
  end

  assign led     = led_q;
  assign mode_o  = mode_q;
  assign speed_o = speed_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with a position-based reference model.
module tb_led_pattern_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned STEP = 8;
  localparam int unsigned DB   = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         key_mode;
  logic         key_speed;
  logic [N-1:0] led;
  logic [1:0]   mode_o;
  logic [1:0]   speed_o;

  always #5 sys_clk = ~sys_clk;

  led_pattern_ctrl #(
    .LED_NUM      (N),
    .STEP_CNT     (STEP),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_mode  (key_mode),
    .key_speed (key_speed),
    .led       (led),
    .mode_o    (mode_o),
    .speed_o   (speed_o)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic [1:0]   mode;
    logic [1:0]   speed;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: patterns tracked as positions/values, keys as raw sample history.
  int m_edge, m_next_tick, m_mode, m_speed;
  int chase_pos, ping_idx, count_val;
  bit blink_on, pm, ps;
  bit hm[DB+2];
  bit hs[DB+2];

  int rm, rs;
  bit rkm, rks;
  bit reached;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    compared++;
    if (act != req) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lim(input int s);
    return int'(STEP) >> s;
  endfunction

  function automatic logic [N-1:0] model_led();
    int p;
    case (m_mode)
      0: return N'(1 << chase_pos);
      1: return blink_on ? {N{1'b1}} : {N{1'b0}};
      2: begin
        p = (ping_idx < int'(N)) ? ping_idx : (2 * int'(N) - 2 - ping_idx);
        return N'(1 << p);
      end
      default: return N'(count_val);
    endcase
  endfunction

  // A press registers once the synchronised-low run reaches DB-1 samples.
  function automatic bit press_seen(input bit h[DB+2]);
    for (int j = 2; j <= int'(DB); j++) if (h[j]) return 1'b0;
    return h[DB+1];
  endfunction

  task automatic model_reset();
    m_edge = 0; m_next_tick = lim(0); m_mode = 0; m_speed = 0;
    chase_pos = 0; ping_idx = 0; count_val = 0; blink_on = 1'b0;
    pm = 1'b0; ps = 1'b0;
    for (int j = 0; j < int'(DB) + 2; j++) begin hm[j] = 1'b1; hs[j] = 1'b1; end
  endtask

  task automatic model_step(input bit km, input bit ks);
    bit restart, tick;
    m_edge++;
    restart = pm || ps;
    tick = !restart && (m_edge == m_next_tick);
    if (pm) begin
      m_mode = (m_mode + 1) % 4;
      chase_pos = 0; ping_idx = 0; count_val = 0; blink_on = 1'b0;
    end
    if (ps) m_speed = (m_speed + 1) % 3;
    if (restart) m_next_tick = m_edge + lim(m_speed);
    else if (tick) begin
      m_next_tick = m_edge + lim(m_speed);
      case (m_mode)
        0: chase_pos = (chase_pos + 1) % int'(N);
        1: blink_on = !blink_on;
        2: ping_idx = (ping_idx + 1) % (2 * int'(N) - 2);
        default: count_val = (count_val + 1) % (1 << N);
      endcase
    end
    for (int j = int'(DB) + 1; j >= 1; j--) begin hm[j] = hm[j-1]; hs[j] = hs[j-1]; end
    hm[0] = km; hs[0] = ks;
    pm = press_seen(hm);
    ps = press_seen(hs);
  endtask

  // One clock: called at a negedge, drives keys, models the edge, queues the expectation.
  task automatic cycle(input bit km, input bit ks);
    exp_t e;
    key_mode = km;
    key_speed = ks;
    @(posedge sys_clk);
    model_step(km, ks);
    e.led = model_led();
    e.mode = 2'(m_mode);
    e.speed = 2'(m_speed);
    exp_q.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic press_mode();
    repeat (DB + 4) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b1);
  endtask

  task automatic press_speed();
    repeat (DB + 4) cycle(1'b1, 1'b0);
  endtask

  // Monitor: compares every registered output against the queued expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led", 32'(led), 32'(e.led));
      check("mode_o", 32'(mode_o), 32'(e.mode));
      check("speed_o", 32'(speed_o), 32'(e.speed));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst = 1'b1; key_mode = 1'b1; key_speed = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_led", 32'(led), 1);
    check("rst_mode", 32'(mode_o), 0);
    check("rst_speed", 32'(speed_o), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();

    // Idle chase, short glitch, long hold, then ping-pong and count.
    repeat (45) cycle(1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b1, 1'b1);
    press_mode();
    repeat (70) cycle(1'b1, 1'b1);
    press_mode();
    repeat (140) cycle(1'b1, 1'b1);
    repeat (3) begin
      press_speed();
      repeat (30) cycle(1'b1, 1'b1);
    end

    // Randomised key activity with random hold/release lengths.
    rm = 0; rs = 0; rkm = 1'b1; rks = 1'b1;
    repeat (3000) begin
      if (rm == 0) begin
        rkm = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
        rm = $urandom_range(1, 12);
      end
      if (rs == 0) begin
        rks = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
        rs = $urandom_range(1, 14);
      end
      rm--; rs--;
      cycle(rkm, rks);
    end
    repeat (4) cycle(1'b1, 1'b1);

    // Reach count mode showing 0110, then reset asynchronously mid-step.
    for (int i = 0; i < 6 && m_mode != 3; i++) press_mode();
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (m_mode == 3 && model_led() == N'(6)) reached = 1'b1;
      else cycle(1'b1, 1'b1);
    end
    if (!reached) begin
      compared++; mismatched++;
      $display("FAIL reach_0110: got mode %0d led %0d expected mode 3 led 6", m_mode, model_led());
    end
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 1);
    check("async_rst_mode", 32'(mode_o), 0);
    check("async_rst_speed", 32'(speed_o), 0);
    key_mode = 1'b1; key_speed = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();

    // Land a mode pulse exactly on a chase tick.
    for (int i = 0; i < 100 && (m_next_tick - (m_edge + 1)) != int'(DB) + 1; i++)
      cycle(1'b1, 1'b1);
    repeat (12) cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b1, 1'b1);

    repeat (3) @(negedge sys_clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
